// File: rtl/genius_pkg.sv
// Shared display-path definitions: segment code width, blank code,
// per-channel hold FSM state encoding and timer sizing helper.
package genius_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } hold_state_e;

  // Timer width able to hold HOLD_CYCLES, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold);
    int unsigned w;
    w = $clog2(hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hold_channel.sv
// One display channel: holds a written code for HOLD_CYCLES clocks, then
// blanks itself and pulses o_done for one cycle.
module hold_channel
  import genius_pkg::*;
#(
  parameter int unsigned      WIDTH       = SEG_W,
  parameter int unsigned      HOLD_CYCLES = 25_000_000,
  parameter logic [WIDTH-1:0] BLANK       = SEG_BLANK
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_code,
  output logic             o_act,
  output logic             o_done
);

  localparam int unsigned      CNT_W    = cnt_width(HOLD_CYCLES);
  localparam bit               TIMED    = (HOLD_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = TIMED ? CNT_W'(HOLD_CYCLES - 1) : '0;

  hold_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_code;
  logic             r_act;
  logic             r_done;

  hold_state_e      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_code_nxt;
  logic             w_act_nxt;
  logic             w_done_nxt;

  // State, timer and output registers.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_code  <= BLANK;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_act   <= w_act_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Priority: clear, then write (retriggers and beats expiry), then timer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_act_nxt   = r_act;
    w_done_nxt  = 1'b0;

    if (i_clr) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_code_nxt  = BLANK;
      w_act_nxt   = 1'b0;
    end else if (i_load) begin
      w_state_nxt = ST_SHOW;
      w_cnt_nxt   = CNT_LOAD;
      w_code_nxt  = i_data;
      w_act_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_SHOW: begin
          if (TIMED) begin
            if (r_cnt == '0) begin
              w_state_nxt = ST_IDLE;
              w_code_nxt  = BLANK;
              w_act_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_code = r_code;
  assign o_act  = r_act;
  assign o_done = r_done;

endmodule

// File: rtl/demux1x2_hold.sv
// Registered 1-to-2 demux for segment codes; each output channel blanks
// itself after a programmable hold time.
module demux1x2_hold
  import genius_pkg::*;
#(
  parameter int unsigned      WIDTH       = SEG_W,
  parameter int unsigned      HOLD_CYCLES = 25_000_000,
  parameter logic [WIDTH-1:0] BLANK       = SEG_BLANK
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic [WIDTH-1:0] ENT_i,
  input  logic             SEL_i,
  input  logic             WR_i,
  input  logic             CLR_i,
  output logic [WIDTH-1:0] OUT0_o,
  output logic [WIDTH-1:0] OUT1_o,
  output logic             ACT0_o,
  output logic             ACT1_o,
  output logic             DONE0_o,
  output logic             DONE1_o
);

  logic w_load0;
  logic w_load1;

  // A clear drops any coincident write.
  assign w_load0 = WR_i & ~CLR_i & ~SEL_i;
  assign w_load1 = WR_i & ~CLR_i &  SEL_i;

  hold_channel #(
    .WIDTH      (WIDTH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .BLANK      (BLANK)
  ) u_ch0 (
    .CLK_i (CLK_i),
    .RST_i (RST_i),
    .i_load(w_load0),
    .i_clr (CLR_i),
    .i_data(ENT_i),
    .o_code(OUT0_o),
    .o_act (ACT0_o),
    .o_done(DONE0_o)
  );

  hold_channel #(
    .WIDTH      (WIDTH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .BLANK      (BLANK)
  ) u_ch1 (
    .CLK_i (CLK_i),
    .RST_i (RST_i),
    .i_load(w_load1),
    .i_clr (CLR_i),
    .i_data(ENT_i),
    .o_code(OUT1_o),
    .o_act (ACT1_o),
    .o_done(DONE1_o)
  );

endmodule

// File: doc/demux1x2_hold.md
Name: demux1x2_hold

Overview:
Registered 1-to-2 demultiplexer for 7-bit segment codes, with a per-channel display-hold timer. It is the distribution end of the display path. A single code source writes a code to output channel 0 or 1. The code stays on that channel for HOLD_CYCLES clocks and then blanks automatically. It drives the two digit displays of the Genius game from one sequencer write port.

Parameters:
WIDTH, 7, code width in bits (one bit per segment a..g).
HOLD_CYCLES, 25_000_000, number of cycles a written code stays visible. 0 means hold indefinitely, with no automatic blanking.
BLANK, 7'b1111111, code driven when a channel is idle (active-low segments, all off).
CNT_W, $clog2(HOLD_CYCLES+1) with a minimum of 1, timer width. Derived; never overridden.

Ports:
CLK_i  input  1  system clock; all flops rise-edge.
RST_i  input  1  reset, asynchronous, active-high.
ENT_i  input  WIDTH  code to write.
SEL_i  input  1  target channel (0 → OUT0_o, 1 → OUT1_o).
WR_i  input  1  write strobe; sampled each rising edge.
CLR_i  input  1  synchronous clear of both channels.
OUT0_o  output  WIDTH  channel 0 code (registered).
OUT1_o  output  WIDTH  channel 1 code (registered).
ACT0_o  output  1  channel 0 is showing a written code.
ACT1_o  output  1  channel 1 is showing a written code.
DONE0_o  output  1  one-cycle pulse when the channel 0 hold expires.
DONE1_o  output  1  one-cycle pulse when the channel 1 hold expires.

Behaviour:
- Reset (RST_i=1, asynchronous):
  - OUT0_o/OUT1_o = BLANK; ACT*=0; DONE*=0; timers=0; both channels in IDLE.
  - Reset mid-hold aborts the hold immediately, with no DONE pulse.
- Each channel has an independent 2-state FSM: IDLE and SHOW.
- Write acceptance: a write is accepted when WR_i=1 and CLR_i=0 at an edge. There is no back-pressure; a write is always accepted.
- Accepted write to channel SEL_i, from either state:
  - OUT<=ENT_i, ACT<=1, cnt<=HOLD_CYCLES-1, state<=SHOW.
  - Latency: one edge. The code is visible in the cycle after the write edge.
  - The other channel is unaffected.
- Rewrite in SHOW: replaces the code and restarts the timer (retrigger). No DONE pulse is generated.
- SHOW without a write, HOLD_CYCLES>0:
  - If cnt==0: OUT<=BLANK, ACT<=0, DONE<=1 for exactly one cycle, state<=IDLE.
  - Otherwise: cnt<=cnt-1.
  - Result: ACT stays high for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=0: the timer is never loaded or decremented. SHOW persists until a rewrite, CLR_i or reset. DONE never asserts.
- HOLD_CYCLES=1: ACT is high for one cycle, and DONE pulses in the following cycle.
- DONE is registered. It is high in the first cycle in which OUT==BLANK, and low otherwise.
- CLR_i=1 at an edge:
  - Both channels go to IDLE, OUT=BLANK, ACT=0, cnt=0.
  - No DONE pulse is generated.
  - CLR_i has priority over a simultaneous WR_i; that write is dropped.
- Simultaneous expiry and write on the same channel at the same edge: the write wins (new code loaded, timer restarted, no DONE).
- Expiry on one channel concurrent with a write to the other channel: both events take effect independently.
- SEL_i and ENT_i are don't-care when WR_i=0.
- All outputs are driven directly from flops, so there are no combinational input-to-output paths.

Decomposition:
- Shared package genius_pkg:
  - SEG_W=7.
  - SEG_BLANK=7'b1111111.
  - The state encoding typedef/localparams ST_IDLE=1'b0, ST_SHOW=1'b1.
- Natural sub-module hold_channel:
  - Contains one FSM, timer, output register and DONE flop.
  - Inputs: CLK_i, RST_i, load, clr, data. Outputs: code, act, done.
  - Instantiated twice. Top-level load_k = WR_i & ~CLR_i & (SEL_i==k).

Test Plan:
All scenarios use HOLD_CYCLES=4 unless stated.
1. Reset, then idle: OUT0/1=7'h7F, ACT=0, DONE=0. Asserting RST_i mid-cycle blanks the outputs without waiting for a clock edge.
2. Write ENT=7'h40, SEL=0, one cycle:
   - OUT0_o=7'h40 and ACT0_o=1 from the next cycle, for exactly 4 cycles.
   - Then OUT0_o=7'h7F with DONE0_o=1 for 1 cycle.
   - OUT1_o stays at 7'h7F throughout.
3. Write 7'h79 to ch1. Two cycles later, rewrite 7'h24 to ch1:
   - OUT1_o changes to 7'h24.
   - ACT1_o stays high 4 cycles past the rewrite; total high time is 6 cycles.
   - Exactly one DONE1_o pulse.
4. Write to ch0, then assert WR_i with SEL=0 at the exact edge where cnt==0: ch0 retriggers, no DONE0_o pulse. Also assert WR_i and CLR_i together: both channels blank, no write occurs, no DONE pulses.
5. Overlap: ch0 is written at t=0 and ch1 at t=2 → DONE0_o at t=5 and DONE1_o at t=7, each 1 cycle wide.
6. HOLD_CYCLES=0 build: write 7'h12 to ch0 and run 1000 cycles → OUT0_o=7'h12, ACT0_o=1, DONE0_o never asserts. Assert CLR_i → OUT0_o returns to 7'h7F.
